cla_addsub_pipe: RTL
====================

// Module: cla_addsub_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor with carry, overflow and zero flags.
//  It generalises the fixed 32-bit ripple-of-4-bit-CLA adder: width, CLA group size and
//  pipeline depth are parameters, subtraction is added, and operands move under a
//  valid/ready handshake. It sits between the operand-fetch stage and the ALU result mux.
// PARAMETERS
//  WIDTH   32  operand/sum width; must be a multiple of GROUP*STAGES
//  GROUP   4   bits per CLA group (generate/propagate lookahead span)
//  STAGES  2   pipeline stages; each stage resolves WIDTH/STAGES bits of the carry chain
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  op         in   1      0 = add, 1 = subtract
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in, add only; ignored when op=1
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  co         out  1      carry out of bit WIDTH-1; for subtract, 1 = no borrow
//  co_prev    out  1      carry into bit WIDTH-1
//  ov         out  1      signed overflow = co ^ co_prev
//  zero       out  1      s == 0
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): all stage valid bits are 0, and all data/flag registers
//    are 0. Outputs are therefore out_valid=0, s=0, co=0, co_prev=0, ov=0, zero=0, in_ready=1.
//    Any beat in flight is discarded. Reset has no synchronous release requirement beyond
//    meeting recovery timing.
//  - Operand prep at accept: bb = op ? ~b : b; cin = op ? 1'b1 : ci.
//  - Stage k (0..STAGES-1) computes slice [k*W/S +: W/S] from GROUP-bit CLA blocks, chained by
//    group carry. Stage k takes the carry registered by stage k-1 (stage 0 uses cin). It
//    registers its slice sum, carry out and the untouched upper operand slices.
//    Lower sums already computed are forwarded unchanged.
//  - The final stage also registers co_prev (carry into MSB), co, ov = co^co_prev and zero.
//  - Latency: exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid=1,
//    when there is no stall. Throughput is one beat per cycle.
//  - Handshake: en = ~out_valid | out_ready; in_ready = en (combinational).
//    When en=1, every stage advances and bubbles propagate with valid=0.
//    When en=0, every stage holds its data and valid bits.
//  - Outputs are registered. s and the flags stay stable while out_valid & ~out_ready.
//    Data is don't-care when out_valid=0, but holds its last value (no X).
//  - A beat is accepted in the same cycle the last result leaves (out_valid & out_ready & in_valid).
//    No beat is lost or duplicated.
//  - in_valid=0 with en=1 inserts a bubble; bubbles never raise out_valid.
//  - Arithmetic wraps modulo 2^WIDTH. ov and co are both meaningful for either op.
//  - STAGES=1 degenerates to a single registered CLA with latency 1.
//  - Elaboration-time error if WIDTH % (GROUP*STAGES) != 0.
// TESTING (defaults WIDTH=32, GROUP=4, STAGES=2 unless noted)
//  - add 0x7FFFFFFF+0x00000001, ci=0 -> after 2 cycles s=0x80000000, co=0, co_prev=1, ov=1, zero=0
//  - add 0xFFFFFFFF+0x00000000, ci=1 -> s=0x00000000, co=1, co_prev=1, ov=0, zero=1
//  - sub 5-7 -> s=0xFFFFFFFE, co=0 (borrow), ov=0; sub 0x80000000-1 -> s=0x7FFFFFFF, co=1, ov=1
//  - Stream 8 beats back-to-back with out_ready toggling 1,0,0,1,...: results in order, none lost
//    or duplicated, and s is stable while stalled
//  - reset_n pulsed low while 2 beats are in flight: out_valid=0 immediately, s=0, and the first
//    beat after release emerges at latency 2
//  - Random compare vs a+b+ci / a-b for WIDTH=16,GROUP=4,STAGES=4 and WIDTH=64,GROUP=8,STAGES=1

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract with carry, overflow and zero flags; latency STAGES cycles.
// Backpressure: one global stall, in_ready = ~out_valid | out_ready; all stages hold while stalled.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             co_prev,
  output logic             ov,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int NG   = SW / GROUP;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % (GROUP * STAGES)) != 0) begin : g_bad_width
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP*STAGES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } beat_t;

  beat_t              src   [STAGES];
  beat_t              st_d  [STAGES];
  beat_t              st_q  [STAGES];
  logic  [STAGES-1:0] src_vld;
  logic  [STAGES-1:0] vld_q;
  logic               cprev_d;
  logic               co_prev_q;
  logic               ov_q;
  logic               zero_q;
  logic               en;

  // Carries of one group, each written as a flat sum of generate/propagate products.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] g,
                                               input logic [GROUP-1:0] p,
                                               input logic             cin);
    logic [GROUP:0] c;
    logic           acc;
    logic           prod;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
    return c;
  endfunction

  assign en       = ~vld_q[LAST] | out_ready;
  assign in_ready = en;

  // Stage 0 sees the prepared operands; later stages see the previous stage register.
  always_comb begin
    src[0].a   = a;
    src[0].b   = op ? ~b : b;
    src[0].s   = '0;
    src[0].c   = op | ci;
    src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k]     = st_q[k-1];
      src_vld[k] = vld_q[k-1];
    end
  end

  always_comb begin
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP-1:0] gg;
    logic [GROUP-1:0] gp;
    logic [GROUP:0]   cv;
    logic             carry;
    int               base;
    ga      = '0;
    gb      = '0;
    gg      = '0;
    gp      = '0;
    cv      = '0;
    carry   = 1'b0;
    base    = 0;
    cprev_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = src[k];
      carry   = src[k].c;
      for (int gi = 0; gi < NG; gi++) begin
        base  = k * SW + gi * GROUP;
        ga    = src[k].a[base +: GROUP];
        gb    = src[k].b[base +: GROUP];
        gg    = ga & gb;
        gp    = ga ^ gb;
        cv    = cla_group(gg, gp, carry);
        st_d[k].s[base +: GROUP] = gp ^ cv[GROUP-1:0];
        if (k == LAST && gi == NG - 1) begin
          cprev_d = cv[GROUP-1];
        end
        carry = cv[GROUP];
      end
      st_d[k].c = carry;
    end
  end

  // Data registers load only on valid beats, so they keep their last value across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= '0;
      co_prev_q <= 1'b0;
      ov_q      <= 1'b0;
      zero_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= src_vld[k];
        if (src_vld[k]) begin
          st_q[k] <= st_d[k];
        end
      end
      if (src_vld[LAST]) begin
        co_prev_q <= cprev_d;
        ov_q      <= st_d[LAST].c ^ cprev_d;
        zero_q    <= ~|st_d[LAST].s;
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign s         = st_q[LAST].s;
  assign co        = st_q[LAST].c;
  assign co_prev   = co_prev_q;
  assign ov        = ov_q;
  assign zero      = zero_q;

endmodule
